// File: rtl/cp0_exc_unit.sv
// CP0 status/cause/EPC registers, event prioritisation and PC redirect for the single-cycle core.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
//
// ack FSM
// state   | meaning
// --------+-------------------------------------------------------
// ST_IDLE | external interrupt may be taken
// ST_ACK  | Inta high for this single cycle
// ST_WAIT | wait for the device to drop its request
module cp0_exc_unit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0008,
  parameter logic [31:0] STATUS_RESET = 32'h0000_000F
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Pc,
  input  logic        V,
  input  logic        ArithOv,
  input  logic        Syscall,
  input  logic        Unimpl,
  input  logic        Eret,
  input  logic        Mtc0,
  input  logic [4:0]  Rd,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  input  logic        Intr,
  output logic        Inta,
  output logic        Exc,
  output logic [31:0] ExcPc
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_WAIT} ack_state_t;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  ack_state_t  state_q, state_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        intr_q;
  logic [31:0] count_q, compare_q;
  logic        tmr_pend_q;

  logic        ev_unimpl, ev_ov, ev_sys, sync_ev;
  logic        ext_int, int_req, take_int, exc_event, do_eret;
  logic [1:0]  exc_code;
  logic        wr_en;
  logic [31:0] cause_rd;

  always_comb begin
    ev_unimpl = Unimpl & status_q[3];
    ev_ov     = ArithOv & V & status_q[1];
    ev_sys    = Syscall & status_q[2];
    sync_ev   = ev_unimpl | ev_ov | ev_sys;
    ext_int   = intr_q & (state_q == ST_IDLE);
    int_req   = (ext_int | tmr_pend_q) & status_q[0];
    // eret beats an interrupt, which simply stays pending for the next cycle
    take_int  = int_req & ~Eret & ~sync_ev;
    exc_event = sync_ev | take_int;
    do_eret   = Eret & ~sync_ev;
    wr_en     = Mtc0 & ~exc_event;
    if (ev_unimpl)   exc_code = 2'b10;
    else if (ev_ov)  exc_code = 2'b11;
    else if (ev_sys) exc_code = 2'b01;
    else             exc_code = 2'b00;
  end

  assign Exc   = exc_event | do_eret;
  assign ExcPc = exc_event ? HANDLER_ADDR : epc_q;
  assign Inta  = (state_q == ST_ACK);

  assign cause_rd = cause_q | {16'b0, tmr_pend_q, 6'b0, intr_q, 8'b0};

  always_comb begin
    RData = 32'b0;
    case (Rd)
      REG_COUNT:   RData = count_q;
      REG_COMPARE: RData = compare_q;
      REG_STATUS:  RData = status_q;
      REG_CAUSE:   RData = cause_rd;
      REG_EPC:     RData = epc_q;
      default:     RData = 32'b0;
    endcase
  end

  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (wr_en && Rd == REG_STATUS) status_d = WData;
    // bits 8 and 15 are live status views, never stored
    if (wr_en && Rd == REG_CAUSE)  cause_d  = WData & ~32'h0000_8100;
    if (wr_en && Rd == REG_EPC)    epc_d    = WData;
    if (exc_event) begin
      status_d      = status_q << 4;
      cause_d[3:2]  = exc_code;
      epc_d         = (exc_code == 2'b01) ? Pc + 32'd4 : Pc;
    end else if (do_eret) begin
      status_d = status_q >> 4;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (take_int && ext_int) state_d = ST_ACK;
      ST_ACK:  state_d = ST_WAIT;
      ST_WAIT: if (!intr_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      status_q <= STATUS_RESET;
      cause_q  <= 32'b0;
      epc_q    <= 32'b0;
      intr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      intr_q   <= Intr;
    end
  end

`ifdef CP0_TIMER_EN
  logic wr_count, wr_compare;
  assign wr_count   = wr_en && (Rd == REG_COUNT);
  assign wr_compare = wr_en && (Rd == REG_COMPARE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q    <= 32'b0;
      compare_q  <= 32'b0;
      tmr_pend_q <= 1'b0;
    end else begin
      count_q    <= wr_count ? WData : count_q + 32'd1;
      if (wr_compare) compare_q <= WData;
      // a Compare write acknowledges the timer, even against a match this edge
      tmr_pend_q <= wr_compare ? 1'b0 : (tmr_pend_q | (count_q == compare_q));
    end
  end
`else
  assign count_q    = 32'b0;
  assign compare_q  = 32'b0;
  assign tmr_pend_q = 1'b0;
`endif

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: priorities, EPC/Status/Cause updates, eret, ack handshake, timer.
module tb_cp0_exc_unit;

  logic        Clk = 1'b0;
  logic        Reset, V, ArithOv, Syscall, Unimpl, Eret, Mtc0, Intr;
  logic [31:0] Pc, WData, RData, ExcPc;
  logic [4:0]  Rd;
  logic        Inta, Exc;

  int n_cmp = 0;
  int n_bad = 0;

  cp0_exc_unit dut (
    .Clk(Clk), .Reset(Reset), .Pc(Pc), .V(V), .ArithOv(ArithOv),
    .Syscall(Syscall), .Unimpl(Unimpl), .Eret(Eret), .Mtc0(Mtc0),
    .Rd(Rd), .WData(WData), .RData(RData), .Intr(Intr), .Inta(Inta),
    .Exc(Exc), .ExcPc(ExcPc)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
    Rd = a;
    #1;
    v = RData;
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    step();
  endtask

  // In the timer build Count==Compare==0 right after reset, so park Compare out of reach
  task automatic release_reset();
    Reset = 1'b0;
`ifdef CP0_TIMER_EN
    Mtc0 = 1'b1; Rd = 5'd11; WData = 32'hFFFF_FFFF;
`endif
    step();
    Mtc0 = 1'b0;
  endtask

  task automatic do_eret();
    Eret = 1'b1;
    step();
    Eret = 1'b0;
  endtask

  logic [31:0] r;
  int exc_cnt, inta_cnt;
  bit found;

  initial begin
    Reset = 1'b1; Pc = 32'h0; V = 0; ArithOv = 0; Syscall = 0; Unimpl = 0;
    Eret = 0; Mtc0 = 0; Intr = 0; Rd = 5'd0; WData = 32'h0;
    apply_reset();
    step();
    rd_reg(5'd12, r); check_val("rst_status", r, 32'h0000_000F);
    rd_reg(5'd13, r); check_val("rst_cause", r, 32'h0);
    rd_reg(5'd14, r); check_val("rst_epc", r, 32'h0);
    check_val("rst_inta", Inta, 1'b0);
    release_reset();
    check_val("idle_exc", Exc, 1'b0);

    // overflow trap
    Pc = 32'h40; ArithOv = 1; V = 1; #1;
    check_val("ov_exc", Exc, 1'b1);
    check_val("ov_excpc", ExcPc, 32'h8);
    step(); ArithOv = 0; V = 0;
    rd_reg(5'd14, r); check_val("ov_epc", r, 32'h40);
    rd_reg(5'd13, r); check_val("ov_code", r[3:2], 2'b11);
    rd_reg(5'd12, r); check_val("ov_status", r, 32'hF0);
    Eret = 1; #1;
    check_val("eret_exc", Exc, 1'b1);
    check_val("eret_excpc", ExcPc, 32'h40);
    step(); Eret = 0;
    rd_reg(5'd12, r); check_val("eret_status", r, 32'h0F);

    ArithOv = 1; V = 0; #1;
    check_val("addnov_exc", Exc, 1'b0);
    step(); ArithOv = 0;

    // unimpl beats syscall and a pending interrupt
    Intr = 1; step();
    Pc = 32'h200; Unimpl = 1; Syscall = 1; #1;
    check_val("pri_exc", Exc, 1'b1);
    check_val("pri_excpc", ExcPc, 32'h8);
    step(); Unimpl = 0; Syscall = 0;
    rd_reg(5'd13, r); check_val("pri_code", r[3:2], 2'b10);
    check_val("pri_intrq", r[8], 1'b1);
    rd_reg(5'd14, r); check_val("pri_epc", r, 32'h200);
    check_val("pri_inta0", Inta, 1'b0);
    Intr = 0; Eret = 1; #1;
    check_val("pri_eret_pc", ExcPc, 32'h200);
    step(); Eret = 0;
    check_val("pri_inta1", Inta, 1'b0);
    step();
    check_val("pri_inta2", Inta, 1'b0);

    // syscall saves the return address
    Pc = 32'h100; Syscall = 1; #1;
    check_val("sys_exc", Exc, 1'b1);
    step(); Syscall = 0;
    rd_reg(5'd14, r); check_val("sys_epc", r, 32'h104);
    rd_reg(5'd13, r); check_val("sys_code", r[3:2], 2'b01);
    do_eret();

    // unimpl beats eret
    Pc = 32'h80; Unimpl = 1; Eret = 1; #1;
    check_val("uer_excpc", ExcPc, 32'h8);
    step(); Unimpl = 0; Eret = 0;
    rd_reg(5'd14, r); check_val("uer_epc", r, 32'h80);
    rd_reg(5'd12, r); check_val("uer_status", r, 32'hF0);
    do_eret();

    // squashed mtc0 is dropped
    Pc = 32'h60; ArithOv = 1; V = 1; Mtc0 = 1; Rd = 5'd14; WData = 32'hDEAD; step();
    ArithOv = 0; V = 0; Mtc0 = 0;
    rd_reg(5'd14, r); check_val("squash_epc", r, 32'h60);
    do_eret();

    // write visible next cycle, old value same cycle
    Mtc0 = 1; Rd = 5'd14; WData = 32'h1234; #1;
    check_val("mtc0_old", RData, 32'h60);
    step(); Mtc0 = 0;
    rd_reg(5'd14, r); check_val("mtc0_new", r, 32'h1234);
    rd_reg(5'd5, r); check_val("unmapped", r, 32'h0);
`ifndef CP0_TIMER_EN
    Mtc0 = 1; Rd = 5'd9; WData = 32'h123; step(); Mtc0 = 0;
    rd_reg(5'd9, r); check_val("count_absent", r, 32'h0);
    rd_reg(5'd11, r); check_val("compare_absent", r, 32'h0);
`endif

    // eret defers an interrupt, then the handshake runs once
    Mtc0 = 1; Rd = 5'd12; WData = 32'hFF; step();
    Rd = 5'd14; WData = 32'h300; step(); Mtc0 = 0;
    Pc = 32'h500; Intr = 1; step();
    Eret = 1; #1;
    check_val("defer_excpc", ExcPc, 32'h300);
    check_val("defer_inta", Inta, 1'b0);
    step(); Eret = 0; #1;
    check_val("int_exc", Exc, 1'b1);
    check_val("int_excpc", ExcPc, 32'h8);
    check_val("int_inta_n1", Inta, 1'b0);
    step();
    check_val("int_inta_n2", Inta, 1'b1);
    rd_reg(5'd14, r); check_val("int_epc", r, 32'h500);
    rd_reg(5'd13, r); check_val("int_code", r[3:2], 2'b00);
    rd_reg(5'd12, r); check_val("int_status", r, 32'hF0);
    exc_cnt = 0; inta_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (Exc) exc_cnt++;
      if (Inta) inta_cnt++;
    end
    check_val("hold_inta", inta_cnt, 0);
    check_val("hold_exc", exc_cnt, 0);
    Eret = 1; #1;
    check_val("int_ret_pc", ExcPc, 32'h500);
    step(); Eret = 0;
    exc_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1; if (Exc) exc_cnt++;
      step();
    end
    check_val("wait_noexc", exc_cnt, 0);
    Intr = 0; step(); step();
    Intr = 1;
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      step();
      if (Exc) found = 1;
    end
    check_val("retake_exc", found, 1'b1);
    step();
    check_val("retake_inta", Inta, 1'b1);
    Intr = 0; do_eret(); step();

    // reset mid-handshake
    Intr = 1; step(); #1;
    check_val("mid_exc", Exc, 1'b1);
    step();
    check_val("mid_inta", Inta, 1'b1);
    apply_reset();
    check_val("mid_rst_inta", Inta, 1'b0);
    release_reset(); #1;
    check_val("mid_retake_exc", Exc, 1'b1);
    step();
    check_val("mid_retake_inta", Inta, 1'b1);
    Intr = 0; do_eret(); step();

`ifdef CP0_TIMER_EN
    Mtc0 = 1; Rd = 5'd11; WData = 32'd10; step();
    Rd = 5'd9; WData = 32'd0; step(); Mtc0 = 0;
    rd_reg(5'd9, r); check_val("tmr_count0", r, 32'd0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (Exc) found = 1;
      else step();
    end
    check_val("tmr_exc", found, 1'b1);
    rd_reg(5'd13, r); check_val("tmr_pend", r[15], 1'b1);
    check_val("tmr_inta", Inta, 1'b0);
    step();
    rd_reg(5'd13, r); check_val("tmr_code", r[3:2], 2'b00);
    Mtc0 = 1; Rd = 5'd11; WData = 32'hFFFF_FFFF; step(); Mtc0 = 0;
    rd_reg(5'd13, r); check_val("tmr_clear", r[15], 1'b0);
    do_eret();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0_exc_unit.md
# cp0_exc_unit

System coprocessor and exception controller for the single-cycle MIPS core. It receives the ALU overflow flag together with decode-side exception flags and the external interrupt line. It prioritises these events and holds the Status, Cause and EPC registers. Each cycle it drives the redirect target that the PC mux uses in place of PC+4.

## Interface
Parameters:
- HANDLER_ADDR, 32'h0000_0008, exception/interrupt handler entry address
- STATUS_RESET, 32'h0000_000F, Status value after reset

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high
- Pc  in  32  address of instruction in execution this cycle
- V  in  1  ALU overflow flag
- ArithOv  in  1  current instruction traps on overflow (add/sub/addi)
- Syscall  in  1  current instruction is syscall
- Unimpl  in  1  current instruction undecodable
- Eret  in  1  current instruction is eret
- Mtc0  in  1  write CP0 register Rd with WData at clock edge
- Rd  in  5  CP0 register select (9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC)
- WData  in  32  mtc0 data
- RData  out  32  combinational read of register Rd (mfc0); unmapped reads return 0
- Intr  in  1  external interrupt request, level, held until Inta
- Inta  out  1  registered interrupt acknowledge, one-cycle pulse
- Exc  out  1  combinational: squash current instruction, load ExcPc into PC
- ExcPc  out  32  redirect target: HANDLER_ADDR or EPC

## Operation
- Intr is registered once (IntrQ). IntrQ is visible as Cause[8].
- Status bits: [0] IE, [1] overflow enable, [2] syscall enable, [3] unimpl enable.
- Event term: a source is enabled when its own Status bit is 1.
- Event priority, highest first:
  - Unimpl & Status[3]
  - ArithOv & V & Status[1]
  - Syscall & Status[2]
  - interrupt: (IntrQ & ack FSM IDLE) | timer pending, gated by Status[0]
- Cause ExcCode[3:2]: 00 interrupt, 01 syscall, 10 unimpl, 11 overflow. Other Cause bits keep their values.
- Taking an event (Exc=1, ExcPc=HANDLER_ADDR). At the edge:
  - EPC <= Pc+4 for syscall; EPC <= Pc otherwise.
  - Cause[3:2] <= code.
  - Status <= Status << 4, which masks all sources while nesting.
- Eret with no event this cycle: Exc=1, ExcPc=EPC, Status <= Status >> 4 (zero fill).
- Eret with an interrupt this cycle: eret wins and the interrupt is deferred one cycle. Eret with Unimpl: Unimpl wins.
- When Exc=1 due to an event, a same-cycle Mtc0 is discarded because the instruction is squashed.
- Ack FSM:
  - IDLE: when an external interrupt is taken -> ACK.
  - ACK: Inta=1 for exactly this cycle -> WAIT.
  - WAIT: while IntrQ=1 stay; when IntrQ=0 -> IDLE.
  - The external interrupt is never taken while in ACK or WAIT.

## Timing
- Reset values:
  - Status=STATUS_RESET
  - Cause=0, EPC=0, Count=0, Compare=0
  - IntrQ=0, Inta=0, FSM=IDLE
- Exc, ExcPc and RData are same-cycle combinational. All register updates happen at the rising Clk edge.
- Intr latency:
  - Intr rises before edge n; IntrQ is high after edge n.
  - Exc is asserted in cycle n+1, if enabled and not masked.
  - Inta is high in cycle n+2.
- Mtc0 writes are visible on RData the next cycle. Reading the register written in the same cycle returns the old value.
- Reset mid-handshake returns the FSM to IDLE with Inta=0. An external device still holding Intr is re-taken after IntrQ resamples.

## Configuration
- CP0_TIMER_EN defined:
  - Count increments every cycle and wraps 32'hFFFF_FFFF -> 0.
  - Mtc0 to Count loads WData; the increment resumes the next cycle.
  - Cause[15] sets when Count==Compare and feeds the interrupt term.
  - Mtc0 to Compare clears Cause[15].
  - The timer needs no Inta.
- Undefined: Count and Compare read 0, writes to them are ignored, and Cause[15]=0.

## Test plan
- Reset, then read Status, Cause and EPC -> 32'h0000000F, 0, 0. Inta=0.
- Pc=32'h40, ArithOv=1, V=1 -> Exc=1, ExcPc=32'h8. Next cycle:
  - EPC=32'h40
  - Cause[3:2]=2'b11
  - Status=32'hF0
- Then eret -> ExcPc=32'h40, Status=32'h0F.
- Unimpl=1, Syscall=1 and IntrQ=1 in the same cycle -> Cause[3:2]=2'b10. EPC=Pc. Inta stays 0.
- Syscall at Pc=32'h100 -> EPC=32'h104, Cause[3:2]=2'b01.
- Intr held high -> exactly one Inta pulse, in cycle n+2.
  - Hold Intr 5 more cycles -> no second Exc.
  - Drop Intr, then raise it again -> a new Exc and Inta.
- CP0_TIMER_EN: Mtc0 Compare=10, Mtc0 Count=0 -> Cause[15]=1 when Count=10. Exc=1, Cause[3:2]=2'b00.
  - Mtc0 Compare -> Cause[15]=0.
  - Without the macro -> RData for Rd=9 is 0.
